hilo_ctrl: RTL

//  EX-stage controller for the HI/LO register pair. Decodes DIV/DIVU/MADD/MSUB/MTHI/MTLO.

---
 rtl/hilo_ctrl_if.sv | 39 +++
 rtl/hilo_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl_if
//  Description : Bundle of the EX-stage request, multi_cycle unit and HI/LO
//                read signals around the HI/LO controller. The slave modport
//                is the controller's view; master is the surrounding
//                pipeline / multi_cycle view.
//  Revision    : 1.0  initial release
// ============================================================================
interface hilo_ctrl_if;
   // EX-stage request
   logic        req_valid;
   logic [7:0]  req_inst;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic        flush;
   // multi_cycle unit
   logic [7:0]  mc_inst;
   logic [31:0] mc_op1;
   logic [31:0] mc_op2;
   logic [63:0] mc_hilo;
   logic [63:0] mc_result;
   logic        mc_done;
   // pipeline control / register read
   logic        stall;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport slave (
      input  req_valid, req_inst, req_op1, req_op2, flush, mc_result, mc_done,
      output mc_inst, mc_op1, mc_op2, mc_hilo, stall, hi_o, lo_o
   );

   modport master (
      output req_valid, req_inst, req_op1, req_op2, flush, mc_result, mc_done,
      input  mc_inst, mc_op1, mc_op2, mc_hilo, stall, hi_o, lo_o
   );
endinterface
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl
//  Description : EX-stage controller for the HI/LO register pair. Decodes
//                DIV/DIVU/MADD/MSUB/MTHI/MTLO, drives the multi_cycle unit,
//                writes HI/LO, stalls while a divide is in flight and drains
//                the divider after a flush.
//                Build option: define HILO_BYPASS_EN to forward the value
//                being written this cycle onto hi_o/lo_o.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_ctrl #(
   parameter int DIV_CYCLES = 36,
   parameter int CNT_W      = 6
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   hilo_ctrl_if.slave    bus
);

   // Instruction codes shared with the decoder and the multi_cycle unit
   localparam logic [7:0] c_inst_div  = 8'h1A;
   localparam logic [7:0] c_inst_divu = 8'h1B;
   localparam logic [7:0] c_inst_madd = 8'hA6;
   localparam logic [7:0] c_inst_msub = 8'hAA;
   localparam logic [7:0] c_inst_mthi = 8'h11;
   localparam logic [7:0] c_inst_mtlo = 8'h13;

   // Last DRAIN cycle: the divider's internal stage counter has run out by then
   localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       inst_q, inst_d;
   logic [31:0]      op1_q, op1_d;
   logic [31:0]      op2_q, op2_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic [7:0]       w_mc_inst;
   logic [31:0]      w_mc_op1;
   logic [31:0]      w_mc_op2;
   logic             w_stall;
   logic [CNT_W-1:0] w_cnt_inc;

   // Request decode
   logic w_is_div, w_is_mac, w_is_mthi, w_is_mtlo;
   assign w_is_div  = bus.req_valid &
                      ((bus.req_inst == c_inst_div) | (bus.req_inst == c_inst_divu));
   assign w_is_mac  = bus.req_valid &
                      ((bus.req_inst == c_inst_madd) | (bus.req_inst == c_inst_msub));
   assign w_is_mthi = bus.req_valid & (bus.req_inst == c_inst_mthi);
   assign w_is_mtlo = bus.req_valid & (bus.req_inst == c_inst_mtlo);

   assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;

   // Next-state, HI/LO write and multi_cycle / stall outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      inst_d    = inst_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      w_mc_inst = 8'h00;
      w_mc_op1  = op1_q;
      w_mc_op2  = op2_q;
      w_stall   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!bus.flush && w_is_div) begin
               inst_d  = bus.req_inst;
               op1_d   = bus.req_op1;
               op2_d   = bus.req_op2;
               cnt_d   = '0;
               state_d = ST_BUSY;
               w_stall = 1'b1;
            end
         end
         ST_BUSY: begin
            w_mc_inst = inst_q;
            cnt_d     = w_cnt_inc;
            w_stall   = ~bus.mc_done;
            if (bus.flush) begin
               // A flush beats a coincident done: the result is discarded
               state_d = bus.mc_done ? ST_IDLE : ST_DRAIN;
            end else if (bus.mc_done) begin
               {hi_d, lo_d} = bus.mc_result;
               state_d      = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            cnt_d   = w_cnt_inc;
            // A new divide must wait until the divider has emptied
            w_stall = w_is_div;
            if (cnt_q == c_drain_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Single-cycle ops never touch the divider, so they also run in DRAIN
      if ((state_q != ST_BUSY) && !bus.flush) begin
         if (w_is_mac) begin
            w_mc_inst    = bus.req_inst;
            w_mc_op1     = bus.req_op1;
            w_mc_op2     = bus.req_op2;
            {hi_d, lo_d} = bus.mc_result;
         end
         if (w_is_mthi) begin
            hi_d = bus.req_op1;
         end
         if (w_is_mtlo) begin
            lo_d = bus.req_op1;
         end
      end
   end

   // State, counter, latched divide operands and HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         inst_q  <= 8'h00;
         op1_q   <= 32'h0;
         op2_q   <= 32'h0;
         hi_q    <= 32'h0;
         lo_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.mc_inst = w_mc_inst;
   assign bus.mc_op1  = w_mc_op1;
   assign bus.mc_op2  = w_mc_op2;
   // The multiply-accumulate always works from the committed registers
   assign bus.mc_hilo = {hi_q, lo_q};
   assign bus.stall   = w_stall;

`ifdef HILO_BYPASS_EN
   assign bus.hi_o = hi_d;
   assign bus.lo_o = lo_d;
`else
   assign bus.hi_o = hi_q;
   assign bus.lo_o = lo_q;
`endif

endmodule
`default_nettype wire
